// File: rtl/dram_arbiter_rr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dram_arbiter_rr
// Description : Round-robin arbiter sharing one single-port data memory among
//               NUM_CORES cores. One request per cycle is forwarded to the
//               memory through registered outputs. Read data comes back tagged
//               to the issuing core through a MEM_LATENCY-deep tag pipeline.
// Ports       : clock, reset      - clock (rising edge), async active-high reset
//               req_rd, req_wr    - per-core read / write requests
//               req_addr          - core i address at [i*ADDR_W +: ADDR_W]
//               req_wdata         - core i write data at [i*DATA_W +: DATA_W]
//               grant             - one-hot, core whose request issues this cycle
//               stall             - core is requesting but not granted
//               rdata, rvalid     - returned read data and one-hot owner
//               err_rdwr          - sticky, a core raised rd and wr together
//               mem_addr/wdata/rden/wren - registered memory command
//               mem_q             - memory read data
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module dram_arbiter_rr #(
   parameter int NUM_CORES   = 4,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        req_rd,
   input  logic [NUM_CORES-1:0]        req_wr,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
   output logic [NUM_CORES-1:0]        grant,
   output logic [NUM_CORES-1:0]        stall,
   output logic [DATA_W-1:0]           rdata,
   output logic [NUM_CORES-1:0]        rvalid,
   output logic                        err_rdwr,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_rden,
   output logic                        mem_wren,
   input  logic [DATA_W-1:0]           mem_q
);

   localparam int                PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_CORES - 1);

   logic [NUM_CORES-1:0] request;
   logic [NUM_CORES-1:0] eligible;
   logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
   logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     owner;      // core that issued the current mem command
   logic                 found;
   logic [PTR_W-1:0]     win_idx;

   logic [MEM_LATENCY-1:0]            tag_v;
   logic [MEM_LATENCY-1:0][PTR_W-1:0] tag_id;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign request = req_rd | req_wr;
   // A core granted this cycle is masked so its still-held request is not reissued.
   assign eligible = request & ~grant;
   assign stall    = request & ~grant;

   // First eligible core searching upward from ptr with wrap.
   always_comb begin
      int sum;
      logic [PTR_W-1:0] cand;
      found   = 1'b0;
      win_idx = '0;
      sum     = 0;
      cand    = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         sum = int'(ptr) + k;
         if (sum >= NUM_CORES) sum = sum - NUM_CORES;
         cand = PTR_W'(sum);
         if (!found && eligible[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rden  <= 1'b0;
         mem_wren  <= 1'b0;
         ptr       <= '0;
         owner     <= '0;
         err_rdwr  <= 1'b0;
      end else begin
         if (|(req_rd & req_wr)) err_rdwr <= 1'b1;
         if (found) begin
            grant          <= '0;
            grant[win_idx] <= 1'b1;
            mem_addr       <= addr_arr[win_idx];
            mem_wdata      <= wdata_arr[win_idx];
            // Write wins when a core raises both enables.
            mem_wren       <= req_wr[win_idx];
            mem_rden       <= req_rd[win_idx] & ~req_wr[win_idx];
            owner          <= win_idx;
            ptr            <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
         end else begin
            grant    <= '0;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
         end
      end
   end

   // Tag pipeline: stage 0 is loaded at the edge ending the cycle in which
   // mem_rden is high, so the last stage lines up with valid mem_q.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_v  <= '0;
         tag_id <= '0;
      end else begin
         tag_v[0]  <= mem_rden;
         tag_id[0] <= owner;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   always_comb begin
      rvalid = '0;
      if (tag_v[MEM_LATENCY-1]) rvalid[tag_id[MEM_LATENCY-1]] = 1'b1;
   end

   assign rdata = tag_v[MEM_LATENCY-1] ? mem_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter_rr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_dram_arbiter_rr
// Description : Self-checking bench for dram_arbiter_rr (MEM_LATENCY = 2) with
//               a behavioural single-port memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dram_arbiter_rr;
   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int AW  = 16;
   localparam int LAT = 2;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    req_rd, req_wr;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    grant, stall, rvalid;
   logic [DW-1:0]   rdata, mem_wdata, mem_q;
   logic [AW-1:0]   mem_addr;
   logic            err_rdwr, mem_rden, mem_wren;

   logic            mem_init;
   logic [DW-1:0]   mem [256];
   logic [DW-1:0]   q_pipe [LAT];

   int checks = 0;
   int passes = 0;

   always #5 clock = ~clock;

   dram_arbiter_rr #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .stall(stall),
      .rdata(rdata), .rvalid(rvalid), .err_rdwr(err_rdwr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   // Memory model: registered read, LAT cycles from mem_rden to mem_q.
   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) begin
            if (i >= 16'h20 && i < 16'h24) mem[i] <= 16'hC000 + 16'(i - 16'h20);
            else if (i == 16'h10)          mem[i] <= 16'hBEEF;
            else                           mem[i] <= 16'h0000;
         end
      end else if (mem_wren) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      if (mem_rden) q_pipe[0] <= mem[mem_addr[7:0]];
      for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
   end
   assign mem_q = q_pipe[LAT-1];

   typedef struct {
      logic [N-1:0] rd;
      logic [N-1:0] wr;
      logic [N-1:0] grant;
      logic [N-1:0] rvalid;
      logic         rden;
      logic         wren;
      logic [DW-1:0] rdata;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_core(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[c*AW +: AW]  = a;
      req_wdata[c*DW +: DW] = d;
   endtask

   task automatic set_defaults();
      for (int c = 0; c < N; c++) set_core(c, 16'h20 + 16'(c), 16'hA000 + 16'(c));
   endtask

   task automatic do_reset();
      req_rd = '0;
      req_wr = '0;
      set_defaults();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      // {rd, wr, grant, rvalid, rden, wren, rdata}
      tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0000};
      tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'h0000};
      tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0, 16'hC000};
      tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0010, 1'b1, 1'b0, 16'hC001};
      tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0100, 1'b1, 1'b0, 16'hC002};
      tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 16'hC003};
      tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 16'hC000};
      tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[8]  = '{4'b1001, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0, 16'h0000};
      tbl[9]  = '{4'b1001, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0000};
      tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 16'hC003};
      tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 16'hC000};
      tbl[12] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 16'h0000};
      tbl[13] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[14] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'h0000};
      tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
      tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 16'hA001};

      // Reset held with all cores requesting.
      reset    = 1'b1;
      mem_init = 1'b1;
      req_rd   = 4'b1111;
      req_wr   = '0;
      req_addr = '0;
      req_wdata = '0;
      set_defaults();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst grant", 32'(grant), 32'h0);
         chk("rst rvalid", 32'(rvalid), 32'h0);
         chk("rst rden", 32'(mem_rden), 32'h0);
         chk("rst wren", 32'(mem_wren), 32'h0);
      end
      chk("rst err", 32'(err_rdwr), 32'h0);
      chk("rst addr", 32'(mem_addr), 32'h0);
      mem_init = 1'b0;

      // Table: fairness, pointer wrap, masking, write/read return order.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         int w;
         req_rd = tbl[i].rd;
         req_wr = tbl[i].wr;
         tick();
         chk($sformatf("tbl%0d grant", i), 32'(grant), 32'(tbl[i].grant));
         chk($sformatf("tbl%0d rden", i), 32'(mem_rden), 32'(tbl[i].rden));
         chk($sformatf("tbl%0d wren", i), 32'(mem_wren), 32'(tbl[i].wren));
         chk($sformatf("tbl%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rvalid));
         chk($sformatf("tbl%0d stall", i), 32'(stall),
             32'((tbl[i].rd | tbl[i].wr) & ~tbl[i].grant));
         if (tbl[i].rvalid != 0)
            chk($sformatf("tbl%0d rdata", i), 32'(rdata), 32'(tbl[i].rdata));
         if (tbl[i].rden || tbl[i].wren) begin
            w = 0;
            for (int c = 0; c < N; c++) if (tbl[i].grant[c]) w = c;
            chk($sformatf("tbl%0d addr", i), 32'(mem_addr), 32'h20 + 32'(w));
         end
      end

      // Single read: core 2 reads 0x0010.
      do_reset();
      set_core(2, 16'h0010, 16'h0000);
      req_rd = 4'b0100;
      tick();
      chk("single grant", 32'(grant), 32'h4);
      chk("single addr", 32'(mem_addr), 32'h10);
      chk("single rden", 32'(mem_rden), 32'h1);
      req_rd = '0;
      tick();
      chk("single early rvalid", 32'(rvalid), 32'h0);
      tick();
      chk("single rvalid", 32'(rvalid), 32'h4);
      chk("single rdata", 32'(rdata), 32'hBEEF);
      tick();
      chk("single rvalid drop", 32'(rvalid), 32'h0);

      // Write then read: core 1 writes 0x1234 to 0x0005, core 3 reads it.
      do_reset();
      set_core(1, 16'h0005, 16'h1234);
      set_core(3, 16'h0005, 16'h0000);
      req_wr = 4'b0010;
      req_rd = 4'b1000;
      tick();
      chk("wr grant", 32'(grant), 32'h2);
      chk("wr wren", 32'(mem_wren), 32'h1);
      chk("wr addr", 32'(mem_addr), 32'h5);
      chk("wr wdata", 32'(mem_wdata), 32'h1234);
      chk("wr stall3", 32'(stall), 32'h8);
      req_wr = '0;
      tick();
      chk("rd grant", 32'(grant), 32'h8);
      chk("rd rden", 32'(mem_rden), 32'h1);
      req_rd = '0;
      tick();
      chk("rd early rvalid", 32'(rvalid), 32'h0);
      tick();
      chk("rd rvalid", 32'(rvalid), 32'h8);
      chk("rd rdata", 32'(rdata), 32'h1234);

      // Error: core 0 raises rd and wr together.
      do_reset();
      set_core(0, 16'h0030, 16'h5555);
      req_rd = 4'b0001;
      req_wr = 4'b0001;
      tick();
      chk("err grant", 32'(grant), 32'h1);
      chk("err wren", 32'(mem_wren), 32'h1);
      chk("err rden", 32'(mem_rden), 32'h0);
      chk("err flag", 32'(err_rdwr), 32'h1);
      chk("err wdata", 32'(mem_wdata), 32'h5555);
      req_rd = '0;
      req_wr = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("err sticky", 32'(err_rdwr), 32'h1);
         chk("err no rvalid", 32'(rvalid), 32'h0);
      end
      do_reset();
      chk("err cleared", 32'(err_rdwr), 32'h0);

      // Abort: reset one cycle after a read grant.
      do_reset();
      req_rd = 4'b0010;
      tick();
      chk("abort grant", 32'(grant), 32'h2);
      req_rd = '0;
      tick();
      reset = 1'b1;
      #1;
      chk("abort async rden", 32'(mem_rden), 32'h0);
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort no rvalid", 32'(rvalid), 32'h0);
      end
      req_rd = 4'b1111;
      tick();
      chk("abort ptr zero", 32'(grant), 32'h1);
      req_rd = '0;
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
